// File: rtl/mul_div_unit.sv
// Iterative 32-bit unsigned multiply/divide unit (MUL, DIVU, REMU, MULHU).
// One shift-add or restoring-divide step per cycle; result written to reg_file via a one-cycle strobe.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  dest_address,
  output logic        busy,
  output logic        write,
  output logic [4:0]  write_address,
  output logic [31:0] write_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_DIVU  = 2'b01,
    OP_REMU  = 2'b10,
    OP_MULHU = 2'b11
  } op_t;

  state_t      state;
  op_t         op_q;
  logic [5:0]  count;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  dest_q;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [32:0] sum;
  logic [32:0] trial;
  logic [31:0] result;
  logic        run_is_mul;
  logic        start_is_mul;

  assign run_is_mul   = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign start_is_mul = (op == 2'b00) || (op == 2'b11);

  // Divide trial uses the bit shifted out of rem so divisors >= 2^31 stay exact.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
    trial    = acc[63:31] - {1'b0, b_q};
    acc_next = acc;
    if (run_is_mul) begin
      acc_next = {sum, acc[31:1]};
    end else if (!trial[32]) begin
      acc_next = {trial[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {acc[62:0], 1'b0};
    end
    case (op_q)
      OP_MUL, OP_DIVU: result = acc_next[31:0];
      default:         result = acc_next[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= OP_MUL;
      count         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      dest_q        <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      write         <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      write <= 1'b0;
      case (state)
        // The edge that leaves DONE may accept a new start, giving 33-cycle throughput.
        IDLE, DONE: begin
          if (start) begin
            op_q   <= op_t'(op);
            a_q    <= operand_a;
            b_q    <= operand_b;
            dest_q <= dest_address;
            acc    <= start_is_mul ? {32'd0, operand_b} : {32'd0, operand_a};
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            count         <= '0;
            write         <= 1'b1;
            write_address <= dest_q;
            write_data    <= result;
            state         <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
